// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder/subtractor: WIDTH-bit carry chain split into STAGES registered segments.
// Define PIPE_RCA_OVF_EN to add the signed-overflow output Ovf.
module pipelined_rca #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
`ifdef PIPE_RCA_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int NS   = (STAGES < 1) ? 1 : STAGES;
  localparam int SEG  = WIDTH / NS;
  localparam int LAST = NS - 1;

  if (STAGES < 1 || (WIDTH % NS) != 0) begin : g_param_err
    $error("pipelined_rca: STAGES must be >= 1 and divide WIDTH");
  end

  logic             valid_q [NS];
  logic             valid_d [NS];
  logic             carry_q [NS];
  logic             carry_d [NS];
  logic [WIDTH-1:0] a_q     [NS];
  logic [WIDTH-1:0] a_d     [NS];
  logic [WIDTH-1:0] b_q     [NS];
  logic [WIDTH-1:0] b_d     [NS];
  logic [WIDTH-1:0] sum_q   [NS];
  logic [WIDTH-1:0] sum_d   [NS];

  logic             adv;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] src_s;
  logic             src_c;
  logic             src_v;
  logic [SEG:0]     seg_r;

  // Bubbles shift like real beats, so the whole pipe moves whenever the output slot frees.
  assign adv      = !valid_q[LAST] || out_ready;
  assign in_ready = adv;

  always_comb begin
    src_a = '0;
    src_b = '0;
    src_s = '0;
    src_c = 1'b0;
    src_v = 1'b0;
    seg_r = '0;
    for (int k = 0; k < NS; k++) begin
      // Stage 0 takes the raw beat (B inverted here for subtract); later stages take the prior register.
      src_a = (k == 0) ? A                : a_q[(k == 0) ? 0 : k - 1];
      src_b = (k == 0) ? (Sub ? ~B : B)   : b_q[(k == 0) ? 0 : k - 1];
      src_s = (k == 0) ? '0               : sum_q[(k == 0) ? 0 : k - 1];
      src_c = (k == 0) ? Cin              : carry_q[(k == 0) ? 0 : k - 1];
      src_v = (k == 0) ? in_valid         : valid_q[(k == 0) ? 0 : k - 1];
      seg_r = {1'b0, src_a[k*SEG +: SEG]} + {1'b0, src_b[k*SEG +: SEG]} + {{SEG{1'b0}}, src_c};
      valid_d[k] = src_v;
      a_d[k]     = src_a;
      b_d[k]     = src_b;
      carry_d[k] = seg_r[SEG];
      sum_d[k]   = src_s;
      sum_d[k][k*SEG +: SEG] = seg_r[SEG-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NS; k++) begin
        valid_q[k] <= 1'b0;
        carry_q[k] <= 1'b0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        sum_q[k]   <= '0;
      end
    end else if (adv) begin
      for (int k = 0; k < NS; k++) begin
        valid_q[k] <= valid_d[k];
        carry_q[k] <= carry_d[k];
        a_q[k]     <= a_d[k];
        b_q[k]     <= b_d[k];
        sum_q[k]   <= sum_d[k];
      end
    end
  end

  assign out_valid = valid_q[LAST];
  assign Sum       = sum_q[LAST];
  assign Cout      = carry_q[LAST];

`ifdef PIPE_RCA_OVF_EN
  logic ovf_d;
  logic ovf_q;

  // a^b^sum at the MSB recovers the carry into the MSB.
  always_comb begin
    ovf_d = a_d[LAST][WIDTH-1] ^ b_d[LAST][WIDTH-1] ^ sum_d[LAST][WIDTH-1] ^ carry_d[LAST];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= ovf_d;
    end
  end

  assign Ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_rca.sv
// Directed bench for pipelined_rca (WIDTH=16, STAGES=4, plus a STAGES=1 instance); scoreboard checks every popped result.
module tb_pipelined_rca;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         Sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Sum;
  logic         Cout;
  logic         in_ready1;
  logic         out_valid1;
  logic [W-1:0] Sum1;
  logic         Cout1;
`ifdef PIPE_RCA_OVF_EN
  logic         Ovf;
  logic         Ovf1;
`endif

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  logic [17:0] exp_q [$];

  always #5 clk = ~clk;

  pipelined_rca #(.WIDTH(W), .STAGES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin), .Sub(Sub),
    .out_valid(out_valid), .out_ready(out_ready), .Sum(Sum), .Cout(Cout)
`ifdef PIPE_RCA_OVF_EN
    , .Ovf(Ovf)
`endif
  );

  pipelined_rca #(.WIDTH(W), .STAGES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .A(A), .B(B), .Cin(Cin), .Sub(Sub),
    .out_valid(out_valid1), .out_ready(1'b1), .Sum(Sum1), .Cout(Cout1)
`ifdef PIPE_RCA_OVF_EN
    , .Ovf(Ovf1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: {ovf, cout, sum}
  function automatic logic [17:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic cin, input logic sub);
    logic [W-1:0] bb;
    logic [W:0]   r;
    logic         ovf;
    bb  = sub ? ~b : b;
    r   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cin};
    ovf = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
    return {ovf, r};
  endfunction

  always @(negedge clk) begin
    logic [17:0] e;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        check("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sb_sum", Sum, e[15:0]);
          check("sb_cout", Cout, e[16]);
`ifdef PIPE_RCA_OVF_EN
          check("sb_ovf", Ovf, e[17]);
`endif
        end
        pops++;
      end
      if (in_valid && in_ready) exp_q.push_back(model(A, B, Cin, Sub));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
    A = a; B = b; Cin = cin; Sub = sub; in_valid = 1'b1;
  endtask

  task automatic run_one(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub,
                         input logic [W-1:0] es, input logic ec);
    int lat;
    beat(a, b, cin, sub);
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 12) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, lat, 4);
    check({tag, "_sum"}, Sum, es);
    check({tag, "_cout"}, Cout, ec);
  endtask

  initial begin
    int cnt;
    int pops0;
    logic [W-1:0] held_sum;
    logic         held_cout;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; Cin = 1'b0; Sub = 1'b0;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_sum", Sum, 0);
    check("rst_cout", Cout, 0);
    check("rst_ready", in_ready, 1);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Wrap, also through the single-stage instance
    check("s1_idle", out_valid1, 0);
    beat(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    check("s1_valid", out_valid1, 1);
    check("s1_sum", Sum1, 16'h0000);
    check("s1_cout", Cout1, 1);
    cnt = 1;
    while (!out_valid && cnt < 12) begin
      tick();
      cnt++;
    end
    check("wrap_lat", cnt, 4);
    check("wrap_sum", Sum, 16'h0000);
    check("wrap_cout", Cout, 1);
    tick();

    run_one("sub_neg", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0);
    run_one("sub_pos", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1);
`ifdef PIPE_RCA_OVF_EN
    run_one("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0);
    check("ovf_add_flag", Ovf, 1);
    run_one("ovf_sub", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1);
    check("ovf_sub_flag", Ovf, 1);
`endif
    tick();

    // Throughput: 100 back-to-back random beats
    pops0 = pops;
    for (int j = 1; j <= 103; j++) begin
      if (j <= 100) beat(W'($urandom_range(0, 65535)), W'($urandom_range(0, 65535)),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else in_valid = 1'b0;
      tick();
      if (j >= 4) check("tp_valid", out_valid, 1);
    end
    tick();
    check("tp_drained", out_valid, 0);
    check("tp_count", pops - pops0, 100);

    // Backpressure with the pipe full
    pops0 = pops;
    for (int i = 0; i < 4; i++) begin
      beat(16'h1000 + 16'(i), 16'h0101 * 16'(i + 1), 1'b0, 1'(i & 1));
      tick();
    end
    beat(16'hABCD, 16'h1234, 1'b1, 1'b0);
    out_ready = 1'b0;
    #1;
    check("bp_ready0", in_ready, 0);
    held_sum  = Sum;
    held_cout = Cout;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("bp_ready", in_ready, 0);
      check("bp_valid", out_valid, 1);
      check("bp_sum", Sum, held_sum);
      check("bp_cout", Cout, held_cout);
    end
    out_ready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      beat(16'h2222 * 16'(i + 1), 16'h0F0F, 1'b1, 1'b1);
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("bp_count", pops - pops0, 9);
    check("bp_qempty", exp_q.size(), 0);

    // Reset with the output slot full and three more beats behind it
    for (int i = 0; i < 4; i++) begin
      beat(16'h1234 + 16'(i), 16'h1111, 1'b0, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    check("mid_valid_pre", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_valid", out_valid, 0);
    check("mid_sum", Sum, 0);
    check("mid_cout", Cout, 0);
    tick(); tick();
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) cnt++;
    end
    check("post_rst_quiet", cnt, 0);
    run_one("post_rst", 16'h00F0, 16'h000F, 1'b1, 1'b0, 16'h0100, 1'b0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
